video_timing_gen: RTL and testbench



---
 rtl/video_timing_gen.sv | 123 ++++++++++++
 tb/tb_video_timing_gen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator (default 1280x720@60, 74.25 MHz pixel clock).
// Define VIDEO_TIMING_FRAME_COUNT_EN to build the completed-frame counter; otherwise frame_count_out is 0.
module video_timing_gen #(
   parameter int ACTIVE_H = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int ACTIVE_V = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter int FC_WIDTH = 6
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   output logic [10:0]         hcount_out,
   output logic [9:0]          vcount_out,
   output logic                hsync_out,
   output logic                vsync_out,
   output logic                active_draw_out,
   output logic                new_frame_out,
   output logic [FC_WIDTH-1:0] frame_count_out
);

   localparam int H_TOTAL = ACTIVE_H + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = ACTIVE_V + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT      = 11'(ACTIVE_H);
   localparam logic [9:0]  V_ACT      = 10'(ACTIVE_V);
   localparam logic [10:0] HS_START   = 11'(ACTIVE_H + H_FP);
   localparam logic [10:0] HS_END     = 11'(ACTIVE_H + H_FP + H_SYNC);
   localparam logic [9:0]  VS_START   = 10'(ACTIVE_V + V_FP);
   localparam logic [9:0]  VS_END     = 10'(ACTIVE_V + V_FP + V_SYNC);

   generate
      if (H_TOTAL > 2047) begin : g_bad_h_total
         $error("video_timing_gen: H_TOTAL %0d does not fit 11 bits", H_TOTAL);
      end
      if (V_TOTAL > 1023) begin : g_bad_v_total
         $error("video_timing_gen: V_TOTAL %0d does not fit 10 bits", V_TOTAL);
      end
   endgenerate

   // ST_IDLE is the reset state; the first edge out of reset only launches pixel (0,0).
   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t      state_q;
   state_t      state_d;
   logic [10:0] next_h;
   logic [9:0]  next_v;
   logic        active_d;
   logic        hsync_d;
   logic        vsync_d;
   logic        new_frame_d;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = ST_RUN;
      next_h  = '0;
      next_v  = '0;
      if (state_q == ST_RUN) begin
         if (hcount_out == H_LAST) begin
            next_h = '0;
            if (vcount_out == V_LAST) begin
               next_v = '0;
            end else begin
               next_v = vcount_out + 10'd1;
            end
         end else begin
            next_h = hcount_out + 11'd1;
            next_v = vcount_out;
         end
      end
   end

   // Strobes are decoded from the coordinate being loaded so they land in the same cycle as it.
   always_comb begin
      active_d    = (next_h < H_ACT) && (next_v < V_ACT);
      hsync_d     = (next_h >= HS_START) && (next_h < HS_END);
      vsync_d     = (next_v >= VS_START) && (next_v < VS_END);
      new_frame_d = (next_h == H_ACT) && (next_v == V_ACT);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         hcount_out      <= '0;
         vcount_out      <= '0;
         hsync_out       <= 1'b0;
         vsync_out       <= 1'b0;
         active_draw_out <= 1'b0;
         new_frame_out   <= 1'b0;
      end else begin
         hcount_out      <= next_h;
         vcount_out      <= next_v;
         hsync_out       <= hsync_d;
         vsync_out       <= vsync_d;
         active_draw_out <= active_d;
         new_frame_out   <= new_frame_d;
      end
   end

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         frame_count_out <= '0;
      end else if (new_frame_d) begin
         frame_count_out <= frame_count_out + FC_WIDTH'(1);
      end
   end
`else
   assign frame_count_out = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a shrunken raster so many whole frames fit in a short run.
// Expected outputs come from a closed-form model of the pixel index since reset release.
module tb_video_timing_gen;

  localparam int AH  = 20;
  localparam int HFP = 3;
  localparam int HSW = 4;
  localparam int HBP = 5;
  localparam int AV  = 10;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int FCW = 6;
  localparam int HT  = AH + HFP + HSW + HBP;
  localparam int VT  = AV + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int NF_OFF = AV * HT + AH;
  localparam int W = 11 + 10 + 4 + FCW;

  logic           clk;
  logic           rst_n;
  logic [10:0]    hcount;
  logic [9:0]     vcount;
  logic           hsync;
  logic           vsync;
  logic           active_draw;
  logic           new_frame;
  logic [FCW-1:0] frame_count;

  int             n_vec;
  int             n_err;
  int             t;
  int             pulses;
  int             last_pulse;
  logic [W-1:0]   exp_q[$];

  video_timing_gen #(
    .ACTIVE_H(AH), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .ACTIVE_V(AV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .FC_WIDTH(FCW)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .hcount_out      (hcount),
    .vcount_out      (vcount),
    .hsync_out       (hsync),
    .vsync_out       (vsync),
    .active_draw_out (active_draw),
    .new_frame_out   (new_frame),
    .frame_count_out (frame_count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at t=%0d: got %h expected %h", tag, t, got, exp);
    end
  endtask

  function automatic logic [W-1:0] dut_vec();
    return {hcount, vcount, hsync, vsync, active_draw, new_frame, frame_count};
  endfunction

  // Pixel index p is the p-th pixel emitted after reset release, starting at (0,0).
  function automatic logic [W-1:0] model(input int p);
    int h, v, frames, fc;
    logic ad, hs, vs, nf;
    h  = p % HT;
    v  = (p / HT) % VT;
    ad = (h < AH) && (v < AV);
    hs = (h >= AH + HFP) && (h < AH + HFP + HSW);
    vs = (v >= AV + VFP) && (v < AV + VFP + VSW);
    nf = (h == AH) && (v == AV);
    frames = (p >= NF_OFF) ? ((p - NF_OFF) / FRAME + 1) : 0;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    fc = frames % (1 << FCW);
`else
    fc = 0;
`endif
    return {11'(h), 10'(v), hs, vs, ad, nf, FCW'(fc)};
  endfunction

  // driver: one clock per pixel; expectation queued at the edge, compared on the falling edge
  task automatic run_cycles(input int n);
    logic [W-1:0] got;
    logic [W-1:0] exp;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      exp_q.push_back(model(t));
      @(negedge clk);
      got = dut_vec();
      exp = exp_q.pop_front();
      check("pixel", got, exp);
      if (new_frame) begin
        pulses++;
        if (last_pulse >= 0)
          check("nf_spacing", W'(t - last_pulse), W'(FRAME));
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        check("fc_in_pulse", W'(frame_count), W'(pulses % (1 << FCW)));
`else
        check("fc_in_pulse", W'(frame_count), W'(0));
`endif
        last_pulse = t;
      end
      t++;
    end
  endtask

  task automatic restart();
    t = 0;
    pulses = 0;
    last_pulse = -1;
    exp_q.delete();
  endtask

  initial begin
    int delta;
    int tgt;
    n_vec = 0;
    n_err = 0;
    restart();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", dut_vec(), '0);
    rst_n = 1'b1;

    // first pixel, first lines and three full frames
    run_cycles(3 * FRAME);
    check("nf_pulses_3_frames", W'(pulses), W'(3));

    // carry on past 64 completed frames so the counter wraps
    run_cycles(63 * FRAME);
    check("nf_pulses_66_frames", W'(pulses), W'(66));

    // stop mid-line at (25,8) and pull reset between clock edges
    tgt = 8 * HT + 25;
    delta = ((tgt - (t % FRAME)) % FRAME + FRAME) % FRAME;
    run_cycles(delta + 1);
    check("pre_reset_pixel", W'({hcount, vcount}), W'({11'd25, 10'd8}));
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_vec(), '0);
    @(negedge clk);
    check("held_reset", dut_vec(), '0);
    rst_n = 1'b1;
    restart();
    run_cycles(2 * HT + 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
